// File: rtl/data_memory_unit.sv
// Data memory stage behind the execute stage's load/store port.
// It accepts one read or write at a time over a level-sensitive 4-phase
// handshake: request -> valueReady -> request low -> valueReady low.
// The access completes LATENCY+1 edges after it is accepted.
module data_memory_unit #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] memAddrLoadStore,
    input  logic [DATA_W-1:0] memValueStore,
    input  logic              readReq,
    input  logic              writeReq,
    input  logic              powerdown,
    output logic [DATA_W-1:0] memValueLoad,
    output logic              valueReady,
    output logic              busy,
    output logic              reqConflict,
    output logic [15:0]       accessCount
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned ACC_W = 16;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              wr_q;
    logic [DATA_W-1:0] load_q;
    logic              ready_q;
    logic              busy_q;
    logic              conflict_q;
    logic [ACC_W-1:0]  count_q;

    // Contents are deliberately not reset; they survive rst.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              req_c;
    logic              commit_c;
    logic [IDX_W-1:0]  idx_c;

    assign req_c    = readReq | writeReq;
    assign commit_c = (state_q == WAIT) && (cnt_q == '0);
    // Truncation gives the address modulo DEPTH (DEPTH is a power of two).
    assign idx_c    = IDX_W'(addr_q);

    // Handshake FSM: accept in IDLE, count down latency in WAIT, hold in RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            load_q     <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
            count_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_c && !powerdown) begin
                        addr_q  <= memAddrLoadStore;
                        data_q  <= memValueStore;
                        wr_q    <= writeReq;
                        cnt_q   <= CNT_W'(LATENCY);
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
                        if (readReq && writeReq) begin
                            conflict_q <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        if (!wr_q) begin
                            load_q <= mem_q[idx_c];
                        end
                        ready_q <= 1'b1;
                        count_q <= count_q + ACC_W'(1);
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (!req_c) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Write commit on the completion edge only; an access aborted by reset never writes.
    always_ff @(posedge clk) begin
        if (commit_c && wr_q) begin
            mem_q[idx_c] <= data_q;
        end
    end

    assign memValueLoad = load_q;
    assign valueReady   = ready_q;
    assign busy         = busy_q;
    assign reqConflict  = conflict_q;
    assign accessCount  = count_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Bench for data_memory_unit. The driver issues handshakes and pushes
// expected completions to a scoreboard. A negedge monitor pops and checks
// each completion when valueReady rises.
module tb_data_memory_unit;

    localparam int unsigned LAT     = 2;
    localparam int unsigned TIMEOUT = 40;

    logic        clk;
    logic        rst;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        rreq, wreq, pd;
    logic [15:0] load;
    logic        vr, busy, conf;
    logic [15:0] acnt;

    logic [7:0]  addr0;
    logic [15:0] wdata0;
    logic        rreq0, wreq0, pd0;
    logic [15:0] load0;
    logic        vr0, busy0, conf0;
    logic [15:0] acnt0;

    typedef struct {
        bit          known;
        logic [15:0] data;
        logic [15:0] count;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] ref_mem [256];
    bit          written [256];
    int          exp_count;
    bit          exp_conf;
    logic [15:0] last_load;
    bit          last_known;
    int          cyc;
    int          n_cmp;
    int          n_err;
    bit          vr_prev;

    data_memory_unit #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .memAddrLoadStore(addr), .memValueStore(wdata),
        .readReq(rreq), .writeReq(wreq), .powerdown(pd),
        .memValueLoad(load), .valueReady(vr), .busy(busy),
        .reqConflict(conf), .accessCount(acnt)
    );

    data_memory_unit #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .LATENCY(0)) u_dut_l0 (
        .clk(clk), .rst(rst),
        .memAddrLoadStore(addr0), .memValueStore(wdata0),
        .readReq(rreq0), .writeReq(wreq0), .powerdown(pd0),
        .memValueLoad(load0), .valueReady(vr0), .busy(busy0),
        .reqConflict(conf0), .accessCount(acnt0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each rising valueReady must match the oldest pending access.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && vr && !vr_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'(vr), 32'(0));
            end else begin
                e = sb.pop_front();
                check("latency_cycle", 32'(cyc), 32'(e.cyc));
                if (e.known) check("load_value", 32'(load), 32'(e.data));
                check("access_count", 32'(acnt), 32'(e.count));
            end
        end
        vr_prev = vr;
    end

    // One full 4-phase access on the main DUT, with optional powerdown and hold.
    task automatic do_access(input bit rd, input bit wr, input logic [7:0] a, input logic [15:0] d,
                             input int hold, input int pd_cycles, input bit pd_in_wait);
        exp_t e;
        int   t;
        @(negedge clk);
        addr = a; wdata = d; rreq = rd; wreq = wr; pd = (pd_cycles > 0);
        for (int i = 0; i < pd_cycles; i++) begin
            @(negedge clk);
            check("pd_busy", 32'(busy), 32'(0));
            check("pd_ready", 32'(vr), 32'(0));
        end
        pd = 1'b0;
        if (wr) begin
            e.known = last_known;
            e.data  = last_load;
            ref_mem[a] = d;
            written[a] = 1'b1;
            if (rd) exp_conf = 1'b1;
        end else begin
            e.known    = written[a];
            e.data     = ref_mem[a];
            last_load  = ref_mem[a];
            last_known = written[a];
        end
        exp_count = (exp_count + 1) % 65536;
        e.count   = 16'(exp_count);
        e.cyc     = cyc + 2 + int'(LAT);
        sb.push_back(e);
        if (pd_in_wait) begin
            @(negedge clk);
            pd = 1'b1;
        end
        t = 0;
        while (!vr && t < int'(TIMEOUT)) begin
            @(negedge clk);
            t++;
            addr  = 8'($urandom);
            wdata = 16'($urandom);
        end
        check("ready_timeout", 32'(vr), 32'(1));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_ready", 32'(vr), 32'(1));
            check("hold_busy", 32'(busy), 32'(1));
        end
        rreq = 1'b0; wreq = 1'b0; pd = 1'b0;
        @(negedge clk);
        check("release_ready", 32'(vr), 32'(0));
        check("release_busy", 32'(busy), 32'(0));
        check("count_after", 32'(acnt), 32'(exp_count));
        check("conflict", 32'(conf), 32'(exp_conf));
    endtask

    // Single access on the zero-latency instance: ready one edge after acceptance.
    task automatic l0_access(input bit wr, input logic [7:0] a, input logic [15:0] d,
                             input logic [15:0] exp_load, input int exp_cnt);
        @(negedge clk);
        addr0 = a; wdata0 = d; wreq0 = wr; rreq0 = !wr;
        @(negedge clk);
        check("l0_accept_ready", 32'(vr0), 32'(0));
        check("l0_accept_busy", 32'(busy0), 32'(1));
        @(negedge clk);
        check("l0_ready", 32'(vr0), 32'(1));
        if (!wr) check("l0_load", 32'(load0), 32'(exp_load));
        check("l0_count", 32'(acnt0), 32'(exp_cnt));
        wreq0 = 1'b0; rreq0 = 1'b0;
        @(negedge clk);
        check("l0_idle_ready", 32'(vr0), 32'(0));
        check("l0_idle_busy", 32'(busy0), 32'(0));
        check("l0_conflict", 32'(conf0), 32'(0));
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          op;
        int          hold;
        int          pdc;
        bit          pdw;
        logic [7:0]  ra;
        rst = 1'b1; pd = 1'b0; rreq = 1'b0; wreq = 1'b0; addr = '0; wdata = '0;
        rreq0 = 1'b0; wreq0 = 1'b0; pd0 = 1'b0; addr0 = '0; wdata0 = '0;
        exp_count = 0; exp_conf = 1'b0; last_load = '0; last_known = 1'b1;
        n_cmp = 0; n_err = 0; vr_prev = 1'b0; cyc = 0;
        #2 rst = 1'b0;
        #1;
        check("rst_load", 32'(load), 32'(0));
        check("rst_ready", 32'(vr), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_conflict", 32'(conf), 32'(0));
        check("rst_count", 32'(acnt), 32'(0));
        @(negedge clk);
        rst = 1'b1;

        // Write then read back.
        do_access(1'b0, 1'b1, 8'd45, 16'd789, 0, 0, 1'b0);
        do_access(1'b1, 1'b0, 8'd45, 16'd0, 0, 0, 1'b0);
        // Request held long after completion: no second access.
        do_access(1'b1, 1'b0, 8'd45, 16'd0, 5, 0, 1'b0);
        // Simultaneous requests: write wins, conflict is sticky.
        do_access(1'b1, 1'b1, 8'd180, 16'd45, 0, 0, 1'b0);
        do_access(1'b1, 1'b0, 8'd180, 16'd0, 0, 0, 1'b0);
        // Powerdown blocks acceptance in IDLE but not an access already in flight.
        do_access(1'b0, 1'b1, 8'd26, 16'h1234, 0, 0, 1'b0);
        do_access(1'b1, 1'b0, 8'd26, 16'd0, 0, 4, 1'b0);
        do_access(1'b1, 1'b0, 8'd26, 16'd0, 1, 0, 1'b1);
        // Reset during a write's wait phase aborts it.
        do_access(1'b0, 1'b1, 8'd12, 16'h0054, 0, 0, 1'b0);
        @(negedge clk);
        addr = 8'd12; wdata = 16'hBEEF; wreq = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst_ready", 32'(vr), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_conflict", 32'(conf), 32'(0));
        check("midrst_count", 32'(acnt), 32'(0));
        check("midrst_load", 32'(load), 32'(0));
        exp_count = 0; exp_conf = 1'b0; last_load = '0; last_known = 1'b1;
        wreq = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        do_access(1'b1, 1'b0, 8'd12, 16'd0, 0, 0, 1'b0);

        // Randomized traffic against the reference array.
        repeat (60) begin
            op   = int'($urandom_range(0, 9));
            ra   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            hold = int'($urandom_range(0, 3));
            pdc  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            pdw  = ($urandom_range(0, 5) == 0);
            if (op < 5)      do_access(1'b1, 1'b0, ra, 16'($urandom), hold, pdc, pdw);
            else if (op < 9) do_access(1'b0, 1'b1, ra, 16'($urandom), hold, pdc, pdw);
            else             do_access(1'b1, 1'b1, ra, 16'($urandom), hold, pdc, pdw);
        end

        // Zero-latency instance.
        l0_access(1'b1, 8'd7, 16'hA5A5, 16'd0, 1);
        l0_access(1'b0, 8'd7, 16'd0, 16'hA5A5, 2);
        l0_access(1'b1, 8'd200, 16'h0F0F, 16'd0, 3);
        l0_access(1'b0, 8'd200, 16'd0, 16'h0F0F, 4);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_memory_unit.md
Name: data_memory_unit

Overview:
Data memory stage that sits directly downstream of the execute stage and serves its load/store port. It accepts one read or write request at a time over a level-sensitive 4-phase handshake (readReq/writeReq -> valueReady). It holds a DEPTH x DATA_W word array and models a fixed access latency. It honours the processor powerdown signal by refusing new requests while letting an in-flight access complete.

Parameters:
DATA_W, 16, data word width
ADDR_W, 8, address width
DEPTH, 256, number of words (2**ADDR_W)
LATENCY, 2, extra wait cycles between acceptance and completion (0..15)

Ports:
clk  in  1  system clock, rising edge active
rst  in  1  asynchronous, active-low reset
memAddrLoadStore  in  ADDR_W  word address from execute stage
memValueStore  in  DATA_W  store data from execute stage
readReq  in  1  load request, level, held until valueReady seen
writeReq  in  1  store request, level, held until valueReady seen
powerdown  in  1  1 = accept no new requests
memValueLoad  out  DATA_W  load result, valid while valueReady=1 after a read
valueReady  out  1  access complete, held until both requests are low
busy  out  1  1 when state != IDLE
reqConflict  out  1  sticky: readReq and writeReq were seen together at acceptance
accessCount  out  16  number of completed accesses, wraps 0xFFFF->0

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, memValueLoad=0, valueReady=0, busy=0, reqConflict=0, accessCount=0. Array contents are not cleared and survive reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE, accept condition: (readReq|writeReq) & ~powerdown at a rising edge.
  - On accept, latch address, store data and op into internal registers; go to WAIT with cnt=LATENCY.
  - If both requests are high, the write wins and reqConflict is set to 1. It stays set until reset.
- WAIT:
  - Each edge with cnt!=0 decrements cnt.
  - At the edge with cnt==0, perform the access on the latched values and go to RESP.
  - A read loads memValueLoad=mem[addr].
  - A write commits mem[addr]=data and leaves memValueLoad unchanged.
  - The same edge sets valueReady=1 and increments accessCount.
- Latency: acceptance at edge A gives valueReady=1 after edge A+LATENCY+1 (LATENCY=2 -> 3 cycles; LATENCY=0 -> 1 cycle).
- RESP:
  - valueReady stays at 1 while readReq|writeReq stays at 1.
  - At the first edge with both requests low, clear valueReady and return to IDLE.
  - A new request needs at least one cycle of IDLE, so back-to-back accesses cost LATENCY+3 cycles minimum.
- Input changes after acceptance (address, data, request type) are ignored until the next acceptance.
- powerdown:
  - Sampled only in IDLE.
  - Asserting it in WAIT or RESP does not abort the access.
  - A request held while powerdown=1 is accepted on the first edge after powerdown falls.
- Reset mid-operation: the access is aborted and the FSM returns to IDLE.
  - If reset occurs before the commit edge, a pending write is not written.
  - A completed write persists.
- Read-after-write to the same address returns the new data.
- Address range: the address is used modulo DEPTH and has no out-of-range error.
- accessCount counts reads and writes. It increments only at the completion edge.

Test Plan:
1. Write then read: write addr 45 data 789, hold writeReq until valueReady, drop it; then read addr 45 -> memValueLoad=789, valueReady 3 cycles after acceptance (LATENCY=2), accessCount=2.
2. 4-phase hold: keep readReq high for 5 cycles after valueReady -> valueReady stays 1 and busy=1. Drop readReq -> valueReady=0 and IDLE next edge; no second access; accessCount unchanged.
3. Conflict: raise readReq and writeReq together with addr 180, data 45 -> write performed (later read of 180 returns 45), reqConflict=1 until rst pulse.
4. Powerdown: powerdown=1 with readReq at addr 26 for 4 cycles -> busy=0, no valueReady; drop powerdown -> accepted next edge, valueReady 3 cycles later. A separate case asserts powerdown while in WAIT -> access still completes.
5. Reset mid-write: write addr 12 data 0xBEEF, assert rst=0 asynchronously in WAIT -> all outputs 0 immediately. After reset, a read of addr 12 returns its pre-write value (previously written 0x0054).
6. Wrap/latency: parameterize LATENCY=0 -> valueReady one edge after acceptance. Preload accessCount near 0xFFFF via 65536 accesses in a long run -> wraps to 0.
